// File: rtl/axi_lite_master_if.sv
// Bundles the command/response port and the five AXI4-Lite channels of axi_lite_master.
// The master modport is the initiator's view; the slave modport is the view of the controller/slave side.
interface axi_lite_master_if #(
  parameter int AXI_ADDR_BW_p = 12
);
  logic                     cmd_valid;
  logic                     cmd_ready;
  logic                     cmd_write;
  logic [AXI_ADDR_BW_p-1:0] cmd_addr;
  logic [31:0]              cmd_wdata;

  logic                     rsp_valid;
  logic                     rsp_ready;
  logic [31:0]              rsp_rdata;
  logic [1:0]               rsp_resp;
  logic                     rsp_timeout;

  logic [AXI_ADDR_BW_p-1:0] axi_awaddr;
  logic                     axi_awvalid;
  logic                     axi_awready;
  logic [31:0]              axi_wdata;
  logic                     axi_wvalid;
  logic                     axi_wready;
  logic [1:0]               axi_bresp;
  logic                     axi_bvalid;
  logic                     axi_bready;
  logic [AXI_ADDR_BW_p-1:0] axi_araddr;
  logic                     axi_arvalid;
  logic                     axi_arready;
  logic [31:0]              axi_rdata;
  logic [1:0]               axi_rresp;
  logic                     axi_rvalid;
  logic                     axi_rready;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready,
    input  axi_awready, axi_wready, axi_bresp, axi_bvalid,
    input  axi_arready, axi_rdata, axi_rresp, axi_rvalid,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_resp, rsp_timeout,
    output axi_awaddr, axi_awvalid, axi_wdata, axi_wvalid, axi_bready,
    output axi_araddr, axi_arvalid, axi_rready
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready,
    output axi_awready, axi_wready, axi_bresp, axi_bvalid,
    output axi_arready, axi_rdata, axi_rresp, axi_rvalid,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_resp, rsp_timeout,
    input  axi_awaddr, axi_awvalid, axi_wdata, axi_wvalid, axi_bready,
    input  axi_araddr, axi_arvalid, axi_rready
  );
endinterface

// File: rtl/axi_lite_master.sv
// Single-outstanding AXI4-Lite initiator: one command in, one AXI write/read, one response out.
// Optional watchdog abort is enabled with `define AXI_LITE_MASTER_TIMEOUT_EN.
module axi_lite_master #(
  parameter int AXI_ADDR_BW_p    = 12,
  parameter int TIMEOUT_CYCLES_p = 1024
) (
  input logic              clk,
  input logic              rst,
  axi_lite_master_if.master bus
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_REQ  = 3'd1,
    WR_RESP = 3'd2,
    RD_REQ  = 3'd3,
    RD_RESP = 3'd4,
    RSP     = 3'd5
  } state_t;

  if (TIMEOUT_CYCLES_p < 2) begin : g_bad_timeout
    $error("axi_lite_master: TIMEOUT_CYCLES_p must be at least 2");
  end

  state_t                   state_r;
  logic                     cmd_ready_r;
  logic                     aw_done_r;
  logic                     w_done_r;
  logic [AXI_ADDR_BW_p-1:0] awaddr_r;
  logic                     awvalid_r;
  logic [31:0]              wdata_r;
  logic                     wvalid_r;
  logic                     bready_r;
  logic [AXI_ADDR_BW_p-1:0] araddr_r;
  logic                     arvalid_r;
  logic                     rready_r;
  logic                     rsp_valid_r;
  logic [31:0]              rsp_rdata_r;
  logic [1:0]               rsp_resp_r;

  logic aw_hs_s;
  logic w_hs_s;

  assign aw_hs_s = awvalid_r & bus.axi_awready;
  assign w_hs_s  = wvalid_r  & bus.axi_wready;

`ifdef AXI_LITE_MASTER_TIMEOUT_EN
  localparam int TO_CNT_BW = $clog2(TIMEOUT_CYCLES_p);
  localparam logic [TO_CNT_BW-1:0] TO_LIMIT = TO_CNT_BW'(TIMEOUT_CYCLES_p - 1);

  logic [TO_CNT_BW-1:0] to_cnt_r;
  logic                 rsp_timeout_r;
  logic                 busy_s;

  assign busy_s = (state_r == WR_REQ) || (state_r == WR_RESP) ||
                  (state_r == RD_REQ) || (state_r == RD_RESP);
  assign bus.rsp_timeout = rsp_timeout_r;
`else
  assign bus.rsp_timeout = 1'b0;
`endif

  // Transaction FSM; every bus-facing output is a flop updated here.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= IDLE;
      cmd_ready_r <= 1'b0;
      aw_done_r   <= 1'b0;
      w_done_r    <= 1'b0;
      awaddr_r    <= '0;
      awvalid_r   <= 1'b0;
      wdata_r     <= 32'h0;
      wvalid_r    <= 1'b0;
      bready_r    <= 1'b0;
      araddr_r    <= '0;
      arvalid_r   <= 1'b0;
      rready_r    <= 1'b0;
      rsp_valid_r <= 1'b0;
      rsp_rdata_r <= 32'h0;
      rsp_resp_r  <= 2'b00;
`ifdef AXI_LITE_MASTER_TIMEOUT_EN
      to_cnt_r      <= '0;
      rsp_timeout_r <= 1'b0;
`endif
    end else begin
      case (state_r)
        IDLE: begin
          if (bus.cmd_valid && cmd_ready_r) begin
            cmd_ready_r <= 1'b0;
            aw_done_r   <= 1'b0;
            w_done_r    <= 1'b0;
            if (bus.cmd_write) begin
              awaddr_r  <= bus.cmd_addr;
              wdata_r   <= bus.cmd_wdata;
              awvalid_r <= 1'b1;
              wvalid_r  <= 1'b1;
              state_r   <= WR_REQ;
            end else begin
              araddr_r  <= bus.cmd_addr;
              arvalid_r <= 1'b1;
              state_r   <= RD_REQ;
            end
          end else begin
            // Ready rises one cycle after reset release and stays up while idle.
            cmd_ready_r <= 1'b1;
          end
        end

        WR_REQ: begin
          if (aw_hs_s) begin
            awvalid_r <= 1'b0;
            aw_done_r <= 1'b1;
          end
          if (w_hs_s) begin
            wvalid_r <= 1'b0;
            w_done_r <= 1'b1;
          end
          if ((aw_done_r || aw_hs_s) && (w_done_r || w_hs_s)) begin
            bready_r <= 1'b1;
            state_r  <= WR_RESP;
          end
        end

        WR_RESP: begin
          if (bus.axi_bvalid && bready_r) begin
            bready_r    <= 1'b0;
            rsp_resp_r  <= bus.axi_bresp;
            rsp_rdata_r <= 32'h0;
            rsp_valid_r <= 1'b1;
            state_r     <= RSP;
          end
        end

        RD_REQ: begin
          if (bus.axi_arready) begin
            arvalid_r <= 1'b0;
            rready_r  <= 1'b1;
            state_r   <= RD_RESP;
          end
        end

        RD_RESP: begin
          if (bus.axi_rvalid && rready_r) begin
            rready_r    <= 1'b0;
            rsp_resp_r  <= bus.axi_rresp;
            rsp_rdata_r <= bus.axi_rdata;
            rsp_valid_r <= 1'b1;
            state_r     <= RSP;
          end
        end

        RSP: begin
          if (bus.rsp_ready) begin
            rsp_valid_r <= 1'b0;
            cmd_ready_r <= 1'b1;
            state_r     <= IDLE;
          end
        end

        default: begin
          awvalid_r   <= 1'b0;
          wvalid_r    <= 1'b0;
          bready_r    <= 1'b0;
          arvalid_r   <= 1'b0;
          rready_r    <= 1'b0;
          rsp_valid_r <= 1'b0;
          cmd_ready_r <= 1'b0;
          state_r     <= IDLE;
        end
      endcase

`ifdef AXI_LITE_MASTER_TIMEOUT_EN
      // Watchdog abort overrides whatever the channel logic scheduled this cycle.
      if (busy_s) begin
        if (to_cnt_r == TO_LIMIT) begin
          awvalid_r     <= 1'b0;
          wvalid_r      <= 1'b0;
          bready_r      <= 1'b0;
          arvalid_r     <= 1'b0;
          rready_r      <= 1'b0;
          rsp_valid_r   <= 1'b1;
          rsp_resp_r    <= 2'b10;
          rsp_rdata_r   <= 32'h0;
          rsp_timeout_r <= 1'b1;
          state_r       <= RSP;
        end else begin
          to_cnt_r <= to_cnt_r + TO_CNT_BW'(1);
        end
      end else begin
        to_cnt_r <= '0;
        if (state_r == IDLE) begin
          rsp_timeout_r <= 1'b0;
        end else begin
          rsp_timeout_r <= rsp_timeout_r;
        end
      end
`endif
    end
  end

  assign bus.cmd_ready   = cmd_ready_r;
  assign bus.rsp_valid   = rsp_valid_r;
  assign bus.rsp_rdata   = rsp_rdata_r;
  assign bus.rsp_resp    = rsp_resp_r;
  assign bus.axi_awaddr  = awaddr_r;
  assign bus.axi_awvalid = awvalid_r;
  assign bus.axi_wdata   = wdata_r;
  assign bus.axi_wvalid  = wvalid_r;
  assign bus.axi_bready  = bready_r;
  assign bus.axi_araddr  = araddr_r;
  assign bus.axi_arvalid = arvalid_r;
  assign bus.axi_rready  = rready_r;

endmodule

// File: tb/tb_axi_lite_master.sv
// Directed bench for axi_lite_master: the slave and controller are driven cycle by cycle from one sequence.
// Timeout abort steps run only when AXI_LITE_MASTER_TIMEOUT_EN is defined.
module tb_axi_lite_master;

  logic clk = 1'b0;
  logic rst;
  int   n_assert = 0;
  int   n_fail   = 0;
  int   bhs_cnt  = 0;
  int   b_base;

  axi_lite_master_if #(.AXI_ADDR_BW_p(12)) bus ();

  axi_lite_master #(
    .AXI_ADDR_BW_p    (12),
    .TIMEOUT_CYCLES_p (16)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Count B-channel handshakes as the slave would see them.
  always @(posedge clk) begin
    if (bus.axi_bvalid && bus.axi_bready) bhs_cnt <= bhs_cnt + 1;
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [127:0] all_outs();
    return 128'({bus.cmd_ready, bus.rsp_valid, bus.rsp_rdata, bus.rsp_resp, bus.rsp_timeout,
                 bus.axi_awaddr, bus.axi_awvalid, bus.axi_wdata, bus.axi_wvalid, bus.axi_bready,
                 bus.axi_araddr, bus.axi_arvalid, bus.axi_rready});
  endfunction

  initial begin
    bus.cmd_valid   = 1'b0;
    bus.cmd_write   = 1'b0;
    bus.cmd_addr    = 12'h000;
    bus.cmd_wdata   = 32'h0;
    bus.rsp_ready   = 1'b0;
    bus.axi_awready = 1'b0;
    bus.axi_wready  = 1'b0;
    bus.axi_bresp   = 2'b00;
    bus.axi_bvalid  = 1'b0;
    bus.axi_arready = 1'b0;
    bus.axi_rdata   = 32'h0;
    bus.axi_rresp   = 2'b00;
    bus.axi_rvalid  = 1'b0;
    rst = 1'b1;
    step();
    step();
    chk("reset_all_outputs_zero", all_outs(), 128'd0);
    rst = 1'b0;
    step();
    chk("idle_cmd_ready", 128'(bus.cmd_ready), 128'd1);

    // Write 0xAB to 0x004, zero-wait slave.
    bus.axi_awready = 1'b1;
    bus.axi_wready  = 1'b1;
    bus.cmd_valid   = 1'b1;
    bus.cmd_write   = 1'b1;
    bus.cmd_addr    = 12'h004;
    bus.cmd_wdata   = 32'h0000_00AB;
    step();
    bus.cmd_valid = 1'b0;
    chk("wr1_valids_c1", 128'({bus.axi_awvalid, bus.axi_wvalid}), 128'd3);
    chk("wr1_awaddr", 128'(bus.axi_awaddr), 128'h004);
    chk("wr1_wdata", 128'(bus.axi_wdata), 128'hAB);
    chk("wr1_cmd_ready_low", 128'(bus.cmd_ready), 128'd0);
    step();
    chk("wr1_valids_c2", 128'({bus.axi_awvalid, bus.axi_wvalid}), 128'd0);
    chk("wr1_bready", 128'(bus.axi_bready), 128'd1);
    chk("wr1_no_rsp_c2", 128'(bus.rsp_valid), 128'd0);
    bus.axi_bvalid = 1'b1;
    bus.axi_bresp  = 2'b00;
    step();
    bus.axi_bvalid = 1'b0;
    chk("wr1_rsp_valid_c3", 128'(bus.rsp_valid), 128'd1);
    chk("wr1_resp_rdata", 128'({bus.rsp_resp, bus.rsp_rdata}), 128'd0);
    chk("wr1_bready_drop", 128'(bus.axi_bready), 128'd0);
    bus.rsp_ready = 1'b1;
    step();
    bus.rsp_ready = 1'b0;
    chk("wr1_back_idle", 128'({bus.rsp_valid, bus.cmd_ready}), 128'b01);

    // Read from 0x008, data after 5 wait cycles.
    bus.axi_arready = 1'b1;
    bus.cmd_valid   = 1'b1;
    bus.cmd_write   = 1'b0;
    bus.cmd_addr    = 12'h008;
    chk("rd_rready_idle", 128'(bus.axi_rready), 128'd0);
    step();
    bus.cmd_valid = 1'b0;
    chk("rd_arvalid", 128'(bus.axi_arvalid), 128'd1);
    chk("rd_araddr", 128'(bus.axi_araddr), 128'h008);
    chk("rd_rready_rdreq", 128'(bus.axi_rready), 128'd0);
    step();
    bus.axi_arready = 1'b0;
    chk("rd_arvalid_drop", 128'(bus.axi_arvalid), 128'd0);
    for (int i = 0; i < 5; i++) begin
      chk("rd_wait_rready", 128'({bus.axi_rready, bus.rsp_valid}), 128'b10);
      step();
    end
    bus.axi_rvalid = 1'b1;
    bus.axi_rdata  = 32'h1234_5678;
    bus.axi_rresp  = 2'b00;
    step();
    bus.axi_rvalid = 1'b0;
    chk("rd_rsp_valid", 128'(bus.rsp_valid), 128'd1);
    chk("rd_rdata", 128'(bus.rsp_rdata), 128'h1234_5678);
    chk("rd_resp", 128'(bus.rsp_resp), 128'd0);
    chk("rd_rready_rsp", 128'(bus.axi_rready), 128'd0);
    bus.rsp_ready = 1'b1;
    step();
    bus.rsp_ready = 1'b0;
    chk("rd_back_idle", 128'(bus.cmd_ready), 128'd1);

    // Write with wready three cycles ahead of awready, BRESP=SLVERR, response stalled 4 cycles.
    b_base          = bhs_cnt;
    bus.axi_awready = 1'b0;
    bus.axi_wready  = 1'b1;
    bus.cmd_valid   = 1'b1;
    bus.cmd_write   = 1'b1;
    bus.cmd_addr    = 12'h010;
    bus.cmd_wdata   = 32'hDEAD_BEEF;
    step();
    bus.cmd_valid = 1'b0;
    chk("wr3_both_valid", 128'({bus.axi_awvalid, bus.axi_wvalid}), 128'b11);
    step();
    bus.axi_wready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("wr3_w_first", 128'({bus.axi_awvalid, bus.axi_wvalid, bus.axi_bready}), 128'b100);
      chk("wr3_awaddr_hold", 128'(bus.axi_awaddr), 128'h010);
      if (i < 2) step();
    end
    bus.axi_awready = 1'b1;
    step();
    bus.axi_awready = 1'b0;
    chk("wr3_aw_done", 128'({bus.axi_awvalid, bus.axi_wvalid, bus.axi_bready}), 128'b001);
    bus.axi_bvalid = 1'b1;
    bus.axi_bresp  = 2'b10;
    step();
    bus.axi_bvalid = 1'b0;
    bus.axi_bresp  = 2'b00;
    for (int i = 0; i < 4; i++) begin
      chk("wr3_rsp_hold", 128'({bus.rsp_valid, bus.rsp_resp, bus.cmd_ready}), 128'b1100);
      step();
    end
    chk("wr3_rsp_hold_last", 128'({bus.rsp_valid, bus.rsp_resp}), 128'b110);
    bus.rsp_ready = 1'b1;
    step();
    bus.rsp_ready = 1'b0;
    chk("wr3_back_idle", 128'({bus.rsp_valid, bus.cmd_ready}), 128'b01);
    chk("wr3_one_b_hs", 128'(bhs_cnt - b_base), 128'd1);

`ifdef AXI_LITE_MASTER_TIMEOUT_EN
    // Read to a slave that never asserts arready.
    bus.cmd_valid = 1'b1;
    bus.cmd_write = 1'b0;
    bus.cmd_addr  = 12'h0F0;
    step();
    bus.cmd_valid = 1'b0;
    for (int i = 0; i < 16; i++) begin
      chk("to_arvalid_held", 128'({bus.axi_arvalid, bus.rsp_valid}), 128'b10);
      step();
    end
    chk("to_arvalid_drop", 128'(bus.axi_arvalid), 128'd0);
    chk("to_rsp", 128'({bus.rsp_valid, bus.rsp_resp, bus.rsp_timeout}), 128'b1101);
    chk("to_rdata_zero", 128'(bus.rsp_rdata), 128'd0);
    bus.rsp_ready = 1'b1;
    step();
    bus.rsp_ready = 1'b0;
    chk("to_back_idle", 128'(bus.cmd_ready), 128'd1);
`endif

    // Reset in WR_RESP, then a clean write.
    bus.axi_awready = 1'b1;
    bus.axi_wready  = 1'b1;
    bus.cmd_valid   = 1'b1;
    bus.cmd_write   = 1'b1;
    bus.cmd_addr    = 12'h020;
    bus.cmd_wdata   = 32'h0000_0055;
    step();
    bus.cmd_valid = 1'b0;
    step();
    chk("rst6_in_wr_resp", 128'(bus.axi_bready), 128'd1);
    rst = 1'b1;
    #1;
    chk("rst6_outputs_zero", all_outs(), 128'd0);
    step();
    rst = 1'b0;
    step();
    chk("rst6_cmd_ready", 128'(bus.cmd_ready), 128'd1);
    bus.cmd_valid = 1'b1;
    bus.cmd_addr  = 12'h030;
    bus.cmd_wdata = 32'h0000_CAFE;
    step();
    bus.cmd_valid = 1'b0;
    chk("wr6_awaddr", 128'({bus.axi_awvalid, bus.axi_awaddr}), 128'h1030);
    chk("wr6_wdata", 128'({bus.axi_wvalid, bus.axi_wdata}), 128'h1_0000_CAFE);
    step();
    bus.axi_bvalid = 1'b1;
    step();
    bus.axi_bvalid = 1'b0;
    chk("wr6_rsp", 128'({bus.rsp_valid, bus.rsp_resp, bus.rsp_timeout}), 128'b1000);
    bus.rsp_ready = 1'b1;
    step();
    bus.rsp_ready = 1'b0;
    chk("wr6_back_idle", 128'({bus.rsp_valid, bus.cmd_ready}), 128'b01);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
